// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back path.
// Imported by regfile_wb_arbiter and wb_queue.
package regfile_pkg;

    localparam logic       ENABLE   = 1'b1;
    localparam logic       DISABLE  = 1'b0;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         ENTRY_W  = 37;

    typedef struct packed {
        logic [4:0]  num;
        logic [31:0] data;
    } wb_entry_t;

    // A read of x0 never matches a pending write.
    function automatic logic entry_hit(input wb_entry_t e, input logic [4:0] addr);
        return (addr != REG_ZERO) && (e.num == addr);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the write-back sources, register-file write port and decode read ports.
// raw_hazard exists only when WB_FORWARD_EN is undefined.
interface regfile_wb_arbiter_if;
    logic        mem_valid;
    logic [4:0]  mem_num;
    logic [31:0] mem_data;
    logic        alu_valid;
    logic [4:0]  alu_num;
    logic [31:0] alu_data;
    logic        stall;
    logic        wb_overflow;
    logic        reg_we;
    logic [4:0]  dstreg_num;
    logic [31:0] dstreg_data;
    logic [4:0]  rd1_num;
    logic [4:0]  rd2_num;
    logic [31:0] rf1_data;
    logic [31:0] rf2_data;
    logic [31:0] src1_data;
    logic [31:0] src2_data;
`ifndef WB_FORWARD_EN
    logic        raw_hazard;
`endif

    modport master (
        output mem_valid, mem_num, mem_data, alu_valid, alu_num, alu_data,
        output rd1_num, rd2_num, rf1_data, rf2_data,
`ifndef WB_FORWARD_EN
        input  raw_hazard,
`endif
        input  stall, wb_overflow, reg_we, dstreg_num, dstreg_data, src1_data, src2_data
    );

    modport slave (
        input  mem_valid, mem_num, mem_data, alu_valid, alu_num, alu_data,
        input  rd1_num, rd2_num, rf1_data, rf2_data,
`ifndef WB_FORWARD_EN
        output raw_hazard,
`endif
        output stall, wb_overflow, reg_we, dstreg_num, dstreg_data, src1_data, src2_data
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_queue.sv
// Circular pending-write buffer: up to two pushes and one pop per cycle.
// entries_o lists the live entries oldest-first (slot k valid when k < count_o).
module wb_queue
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push0_i,
    input  wb_entry_t                push0_entry_i,
    input  logic                     push1_i,
    input  wb_entry_t                push1_entry_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    output logic [CNT_W-1:0]         count_o,
    output logic [DEPTH*ENTRY_W-1:0] entries_o,
    output logic                     drop_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W:0]   room_s;
    logic             pop_s;
    logic             acc0_s;
    logic             acc1_s;
    logic [1:0]       push_n_s;

    // Free space counts the entry popped this cycle, so a full queue can still take one push.
    always_comb begin
        pop_s    = pop_i && (count_q != {CNT_W{1'b0}});
        room_s   = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + {{CNT_W{1'b0}}, pop_s};
        acc0_s   = push0_i && (room_s >= (CNT_W+1)'(1));
        acc1_s   = push1_i && (room_s >= (CNT_W+1)'(2));
        drop_o   = (push0_i && !acc0_s) || (push1_i && !acc1_s);
        push_n_s = {1'b0, acc0_s} + {1'b0, acc1_s};
        head_d   = head_q + PTR_W'(pop_s);
        tail_d   = tail_q + PTR_W'(push_n_s);
        count_d  = count_q + CNT_W'(push_n_s) - CNT_W'(pop_s);
    end

    // Pointer, count and storage update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (acc0_s) begin
                mem_q[tail_q] <= push0_entry_i;
            end
            if (acc1_s) begin
                mem_q[tail_q + PTR_W'(1)] <= push1_entry_i;
            end
        end
    end

    // Oldest-first view of the storage for the forwarding search.
    always_comb begin
        entries_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            entries_o[k*ENTRY_W +: ENTRY_W] = mem_q[head_q + PTR_W'(k)];
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: merges load and ALU results into one register-file write port,
// queues collisions in program order and forwards pending data (WB_FORWARD_EN).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t                mem_e_s, alu_e_s, head_s;
    wb_entry_t                slot_d, slot_q;
    wb_entry_t                push0_e_s, push1_e_s;
    logic                     slot_we_d, slot_we_q;
    logic                     mem_ok_s, alu_ok_s;
    logic                     pop_s, push0_s, push1_s, drop_s;
    logic                     overflow_q;
    logic [CNT_W-1:0]         count_s;
    logic [DEPTH*ENTRY_W-1:0] entries_s;

    assign mem_e_s  = wb_entry_t'({bus.mem_num, bus.mem_data});
    assign alu_e_s  = wb_entry_t'({bus.alu_num, bus.alu_data});
    assign mem_ok_s = bus.mem_valid && (bus.mem_num != REG_ZERO);
    assign alu_ok_s = bus.alu_valid && (bus.alu_num != REG_ZERO);

    // Oldest item takes the slot (head, then load, then ALU); the rest go to the tail in order.
    always_comb begin
        slot_we_d = DISABLE;
        slot_d    = '0;
        pop_s     = 1'b0;
        push0_s   = 1'b0;
        push1_s   = 1'b0;
        push0_e_s = '0;
        push1_e_s = '0;
        if (count_s != {CNT_W{1'b0}}) begin
            slot_we_d = ENABLE;
            slot_d    = head_s;
            pop_s     = 1'b1;
            if (mem_ok_s) begin
                push0_s   = 1'b1;
                push0_e_s = mem_e_s;
                push1_s   = alu_ok_s;
                push1_e_s = alu_e_s;
            end else begin
                push0_s   = alu_ok_s;
                push0_e_s = alu_e_s;
            end
        end else if (mem_ok_s) begin
            slot_we_d = ENABLE;
            slot_d    = mem_e_s;
            push0_s   = alu_ok_s;
            push0_e_s = alu_e_s;
        end else if (alu_ok_s) begin
            slot_we_d = ENABLE;
            slot_d    = alu_e_s;
        end else begin
            slot_we_d = DISABLE;
        end
    end

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk           (clk),
        .rst           (rst),
        .push0_i       (push0_s),
        .push0_entry_i (push0_e_s),
        .push1_i       (push1_s),
        .push1_entry_i (push1_e_s),
        .pop_i         (pop_s),
        .head_o        (head_s),
        .count_o       (count_s),
        .entries_o     (entries_s),
        .drop_o        (drop_s)
    );

    // Write slot and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_we_q  <= DISABLE;
            slot_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            slot_we_q  <= slot_we_d;
            slot_q     <= slot_d;
            overflow_q <= overflow_q | drop_s;
        end
    end

    assign bus.reg_we      = slot_we_q;
    assign bus.dstreg_num  = slot_q.num;
    assign bus.dstreg_data = slot_q.data;
    assign bus.wb_overflow = overflow_q;
    assign bus.stall       = (count_s >= CNT_W'(DEPTH - 1));

`ifdef WB_FORWARD_EN
    logic [31:0] src1_s, src2_s;

    // Later (younger) matches override earlier ones; the slot is older than every queued entry.
    always_comb begin
        wb_entry_t e;
        src1_s = bus.rf1_data;
        src2_s = bus.rf2_data;
        src1_s = (slot_we_q && entry_hit(slot_q, bus.rd1_num)) ? slot_q.data : src1_s;
        src2_s = (slot_we_q && entry_hit(slot_q, bus.rd2_num)) ? slot_q.data : src2_s;
        for (int k = 0; k < DEPTH; k++) begin
            e      = entries_s[k*ENTRY_W +: ENTRY_W];
            src1_s = ((CNT_W'(k) < count_s) && entry_hit(e, bus.rd1_num)) ? e.data : src1_s;
            src2_s = ((CNT_W'(k) < count_s) && entry_hit(e, bus.rd2_num)) ? e.data : src2_s;
        end
        src1_s = (bus.rd1_num == REG_ZERO) ? 32'd0 : src1_s;
        src2_s = (bus.rd2_num == REG_ZERO) ? 32'd0 : src2_s;
    end

    assign bus.src1_data = src1_s;
    assign bus.src2_data = src2_s;
`else
    logic hazard_s;

    // Any pending write to a nonzero read address stalls decode.
    always_comb begin
        wb_entry_t e;
        hazard_s = slot_we_q && (entry_hit(slot_q, bus.rd1_num) || entry_hit(slot_q, bus.rd2_num));
        for (int k = 0; k < DEPTH; k++) begin
            e        = entries_s[k*ENTRY_W +: ENTRY_W];
            hazard_s = hazard_s | ((CNT_W'(k) < count_s) &&
                       (entry_hit(e, bus.rd1_num) || entry_hit(e, bus.rd2_num)));
        end
    end

    assign bus.raw_hazard = hazard_s;
    assign bus.src1_data  = bus.rf1_data;
    assign bus.src2_data  = bus.rf2_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH = 4); covers either WB_FORWARD_EN build.
module tb_regfile_wb_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic mv, input logic [4:0] mn, input logic [31:0] md,
                       input logic av, input logic [4:0] an, input logic [31:0] ad);
        bus.mem_valid = mv;
        bus.mem_num   = mn;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_num   = an;
        bus.alu_data  = ad;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] num, input logic [31:0] data);
        chk({tag, ".we"}, {31'd0, bus.reg_we}, {31'd0, we});
        if (we) begin
            chk({tag, ".num"},  {27'd0, bus.dstreg_num}, {27'd0, num});
            chk({tag, ".data"}, bus.dstreg_data, data);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [2:0] c);
        chk(tag, {29'd0, dut.u_queue.count_q}, {29'd0, c});
    endtask

    logic [31:0] drain_exp [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        idle();
        bus.rd1_num  = 5'd0;
        bus.rd2_num  = 5'd0;
        bus.rf1_data = 32'h0000_0055;
        bus.rf2_data = 32'h0000_0066;
        step();
        step();

        // Reset values
        chk_wr("rst", 1'b0, 5'd0, 32'd0);
        chk("rst.num",  {27'd0, bus.dstreg_num}, 32'd0);
        chk("rst.data", bus.dstreg_data, 32'd0);
        chk("rst.stall", {31'd0, bus.stall}, 32'd0);
        chk("rst.ovf", {31'd0, bus.wb_overflow}, 32'd0);
        rst = 1'b1;
        step();

        // Collision: load wins the slot, ALU follows next cycle
        drv(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        step();
        idle();
        chk_wr("col.n1", 1'b1, 5'd5, 32'h11);
        chk_cnt("col.cnt1", 3'd1);
        step();
        chk_wr("col.n2", 1'b1, 5'd5, 32'h22);
        chk_cnt("col.cnt2", 3'd0);
        step();
        chk_wr("col.n3", 1'b0, 5'd0, 32'd0);

        // x0 destination discarded
        drv(1'b1, 5'd3, 32'hAB, 1'b1, 5'd0, 32'h99);
        step();
        idle();
        chk_wr("zero.n1", 1'b1, 5'd3, 32'hAB);
        chk_cnt("zero.cnt", 3'd0);
        step();
        chk_wr("zero.n2", 1'b0, 5'd0, 32'd0);

        // x7 pending as 0x1 (slot) then 0x2 (queue)
        drv(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
        bus.rd1_num = 5'd7;
        step();
        idle();
`ifdef WB_FORWARD_EN
        chk("fwd.youngest", bus.src1_data, 32'h2);
        bus.rd1_num = 5'd0;
        #1;
        chk("fwd.x0", bus.src1_data, 32'h0);
        bus.rd2_num = 5'd7;
        #1;
        chk("fwd.port2", bus.src2_data, 32'h2);
        bus.rd2_num = 5'd0;
        bus.rd1_num = 5'd7;
        step();
        chk("fwd.slot", bus.src1_data, 32'h2);
        step();
        chk("fwd.none", bus.src1_data, 32'h55);
`else
        chk("raw.src1", bus.src1_data, 32'h55);
        chk("raw.hz1", {31'd0, bus.raw_hazard}, 32'd1);
        bus.rd1_num = 5'd0;
        #1;
        chk("raw.x0", {31'd0, bus.raw_hazard}, 32'd0);
        bus.rd2_num = 5'd7;
        #1;
        chk("raw.port2", {31'd0, bus.raw_hazard}, 32'd1);
        bus.rd2_num = 5'd0;
        bus.rd1_num = 5'd7;
        step();
        chk("raw.slot", {31'd0, bus.raw_hazard}, 32'd1);
        step();
        chk("raw.drained", {31'd0, bus.raw_hazard}, 32'd0);
        chk("raw.src1b", bus.src1_data, 32'h55);
`endif
        bus.rd1_num = 5'd0;

        // Fill: dual requests until stall, then force past it
        drv(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102);
        step();
        chk("full.s1.stall", {31'd0, bus.stall}, 32'd0);
        chk_wr("full.s1", 1'b1, 5'd1, 32'h101);
        drv(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104);
        step();
        chk("full.s2.stall", {31'd0, bus.stall}, 32'd0);
        drv(1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106);
        step();
        chk_cnt("full.s3.cnt", 3'd3);
        chk("full.s3.stall", {31'd0, bus.stall}, 32'd1);
        idle();
        step();
        chk_cnt("full.idle.cnt", 3'd2);
        chk("full.idle.stall", {31'd0, bus.stall}, 32'd0);
        chk("full.idle.ovf", {31'd0, bus.wb_overflow}, 32'd0);
        drv(1'b1, 5'd7, 32'h107, 1'b1, 5'd8, 32'h108);
        step();
        chk("full.s4.stall", {31'd0, bus.stall}, 32'd1);
        drv(1'b1, 5'd9, 32'h109, 1'b1, 5'd10, 32'h10A);
        step();
        chk_cnt("full.f1.cnt", 3'd4);
        chk("full.f1.ovf", {31'd0, bus.wb_overflow}, 32'd0);
        chk_wr("full.f1", 1'b1, 5'd6, 32'h106);
        drv(1'b1, 5'd11, 32'h10B, 1'b1, 5'd12, 32'h10C);
        step();
        idle();
        chk_cnt("full.f2.cnt", 3'd4);
        chk("full.f2.ovf", {31'd0, bus.wb_overflow}, 32'd1);
        chk_wr("full.f2", 1'b1, 5'd7, 32'h107);
        drain_exp[0] = 32'h108;
        drain_exp[1] = 32'h109;
        drain_exp[2] = 32'h10A;
        drain_exp[3] = 32'h10B;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("drain%0d", i), bus.dstreg_data, drain_exp[i]);
        end
        step();
        chk_wr("drain.end", 1'b0, 5'd0, 32'd0);
        chk("ovf.sticky", {31'd0, bus.wb_overflow}, 32'd1);

        // Reset with three entries queued
        drv(1'b1, 5'd1, 32'h201, 1'b1, 5'd2, 32'h202);
        step();
        drv(1'b1, 5'd3, 32'h203, 1'b1, 5'd4, 32'h204);
        step();
        drv(1'b1, 5'd5, 32'h205, 1'b1, 5'd6, 32'h206);
        step();
        idle();
        chk_cnt("mrst.pre", 3'd3);
        rst = 1'b0;
        #1;
        chk("mrst.we", {31'd0, bus.reg_we}, 32'd0);
        chk("mrst.num", {27'd0, bus.dstreg_num}, 32'd0);
        chk("mrst.data", bus.dstreg_data, 32'd0);
        chk("mrst.stall", {31'd0, bus.stall}, 32'd0);
        chk("mrst.ovf", {31'd0, bus.wb_overflow}, 32'd0);
        chk_cnt("mrst.cnt", 3'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mrst.after%0d", i), {31'd0, bus.reg_we}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
